// File: rtl/spatz_pkg.sv
// Shared VRF types and sizing.
//   NRVREG x NrWordsPerVector words of VRegDataWidth bits, byte-enabled.
//   Word addresses are split into a bank index (low bits) and a row (upper bits).
package spatz_pkg;

   localparam int unsigned NRVREG           = 32;
   localparam int unsigned NrWordsPerVector = 8;
   localparam int unsigned VRegDataWidth    = 32;
   localparam int unsigned VRegBytes        = VRegDataWidth / 8;
   localparam int unsigned VRegAddrWidth    = $clog2(NRVREG * NrWordsPerVector);

   localparam int unsigned NrBanks          = 4;
   localparam int unsigned BankIdxWidth     = $clog2(NrBanks);
   localparam int unsigned RowWidth         = VRegAddrWidth - BankIdxWidth;

   typedef logic [VRegAddrWidth-1:0] vreg_addr_t;
   typedef logic [VRegDataWidth-1:0] vreg_data_t;
   typedef logic [VRegBytes-1:0]     vreg_be_t;

   typedef logic [BankIdxWidth-1:0]  vrf_bank_idx_t;
   typedef logic [RowWidth-1:0]      vrf_row_t;

endpackage

// File: rtl/spatz_vrf_bank.sv
// Single VRF storage bank.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset, clears every row
//   raddr_i  : read row; rdata_o is combinational from it
//   we_i     : write enable; waddr_i/wdata_i/wbe_i commit on the rising edge,
//              only bytes with wbe_i set are updated
module spatz_vrf_bank
   import spatz_pkg::*;
#(
   parameter int unsigned RowW = $bits(vrf_row_t)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [RowW-1:0] raddr_i,
   output vreg_data_t      rdata_o,
   input  logic            we_i,
   input  logic [RowW-1:0] waddr_i,
   input  vreg_data_t      wdata_i,
   input  vreg_be_t        wbe_i
);

   localparam int unsigned NrRows = 2 ** RowW;

   vreg_data_t [NrRows-1:0] mem_q;

   assign rdata_o = mem_q[raddr_i];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '0;
      end else if (we_i) begin
         for (int unsigned i = 0; i < VRegBytes; i++) begin
            if (wbe_i[i]) begin
               mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/spatz_vrf_responder.sv
// Banked vector register file with multi-port combinational reads.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   waddr_i/wdata_i/we_i/wbe_i : write port, always accepted (wvalid_o = we_i)
//   raddr_i/re_i  : per-port read request, held by the requester until granted
//   rdata_o/rvalid_o : per-port read response in the grant cycle, 0 otherwise
// Each bank serves one read per cycle; conflicts are resolved by a per-bank
// round-robin pointer that only moves when the bank saw contention.
module spatz_vrf_responder
   import spatz_pkg::*;
#(
   parameter int unsigned NrReadPorts = 3,
   parameter int unsigned NrBanks     = spatz_pkg::NrBanks
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  vreg_addr_t                         waddr_i,
   input  vreg_data_t                         wdata_i,
   input  logic                               we_i,
   input  vreg_be_t                           wbe_i,
   output logic                               wvalid_o,
   input  vreg_addr_t [NrReadPorts-1:0]       raddr_i,
   input  logic       [NrReadPorts-1:0]       re_i,
   output vreg_data_t [NrReadPorts-1:0]       rdata_o,
   output logic       [NrReadPorts-1:0]       rvalid_o
);

   localparam int unsigned BankW = $clog2(NrBanks);
   localparam int unsigned RowW  = VRegAddrWidth - BankW;
   localparam int unsigned PortW = (NrReadPorts > 1) ? $clog2(NrReadPorts) : 1;

   typedef logic [PortW-1:0] port_idx_t;

   port_idx_t [NrBanks-1:0]              rr_q, rr_d;
   logic      [NrBanks-1:0][NrReadPorts-1:0] bank_req;
   logic      [NrBanks-1:0]              gnt_valid;
   port_idx_t [NrBanks-1:0]              gnt_idx;
   logic      [NrBanks-1:0][RowW-1:0]    bank_raddr;
   vreg_data_t [NrBanks-1:0]             bank_rdata;
   logic      [NrBanks-1:0]              bank_we;
   logic      [NrReadPorts-1:0]          port_gnt;

   assign wvalid_o = we_i;
   assign rvalid_o = port_gnt;

   // Per-bank arbitration: scan ports starting at rr_q, wrapping, and take the
   // first requester. The pointer moves past the winner only under contention.
   always_comb begin
      int unsigned nreq;
      int unsigned idx;
      nreq       = 0;
      idx        = 0;
      bank_req   = '0;
      gnt_valid  = '0;
      gnt_idx    = '0;
      bank_raddr = '0;
      port_gnt   = '0;
      rr_d       = rr_q;
      for (int unsigned b = 0; b < NrBanks; b++) begin
         nreq = 0;
         for (int unsigned p = 0; p < NrReadPorts; p++) begin
            if (re_i[p] && (raddr_i[p][BankW-1:0] == BankW'(b))) begin
               bank_req[b][p] = 1'b1;
               nreq++;
            end
         end
         for (int unsigned off = 0; off < NrReadPorts; off++) begin
            idx = 32'(rr_q[b]) + off;
            if (idx >= NrReadPorts) idx = idx - NrReadPorts;
            if (!gnt_valid[b] && bank_req[b][idx]) begin
               gnt_valid[b] = 1'b1;
               gnt_idx[b]   = PortW'(idx);
            end
         end
         if (gnt_valid[b]) begin
            port_gnt[gnt_idx[b]] = 1'b1;
            bank_raddr[b]        = raddr_i[gnt_idx[b]][VRegAddrWidth-1:BankW];
            if (nreq >= 2) begin
               if (gnt_idx[b] == PortW'(NrReadPorts - 1)) rr_d[b] = '0;
               else                                        rr_d[b] = gnt_idx[b] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int unsigned p = 0; p < NrReadPorts; p++) begin
         if (port_gnt[p]) rdata_o[p] = bank_rdata[raddr_i[p][BankW-1:0]];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= '0;
      else         rr_q <= rr_d;
   end

   for (genvar b = 0; b < NrBanks; b++) begin : g_bank
      assign bank_we[b] = we_i && (waddr_i[BankW-1:0] == BankW'(b));

      spatz_vrf_bank #(
         .RowW (RowW)
      ) i_bank (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .raddr_i (bank_raddr[b]),
         .rdata_o (bank_rdata[b]),
         .we_i    (bank_we[b]),
         .waddr_i (waddr_i[VRegAddrWidth-1:BankW]),
         .wdata_i (wdata_i),
         .wbe_i   (wbe_i)
      );
   end

endmodule

// File: tb/tb_spatz_vrf_responder.sv
module tb_spatz_vrf_responder;
   import spatz_pkg::*;

   localparam int unsigned NP = 3;

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   vreg_addr_t            waddr;
   vreg_data_t            wdata;
   logic                  we;
   vreg_be_t              wbe;
   logic                  wvalid;
   vreg_addr_t [NP-1:0]   raddr;
   logic       [NP-1:0]   re;
   vreg_data_t [NP-1:0]   rdata;
   logic       [NP-1:0]   rvalid;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   spatz_vrf_responder #(
      .NrReadPorts (NP),
      .NrBanks     (4)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
      .we_i     (we),
      .wbe_i    (wbe),
      .wvalid_o (wvalid),
      .raddr_i  (raddr),
      .re_i     (re),
      .rdata_o  (rdata),
      .rvalid_o (rvalid)
   );

   typedef struct {
      string      name;
      logic       we;
      vreg_addr_t wa;
      vreg_data_t wd;
      vreg_be_t   be;
      logic [2:0] re;
      vreg_addr_t a0, a1, a2;
      logic [2:0] ev;
      vreg_data_t d0, d1, d2;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic w, input int unsigned wa,
                               input logic [31:0] wd, input logic [3:0] be, input logic [2:0] r,
                               input int unsigned a0, input int unsigned a1, input int unsigned a2,
                               input logic [2:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2);
      vec_t v;
      v.name = n; v.we = w; v.wa = vreg_addr_t'(wa); v.wd = wd; v.be = be; v.re = r;
      v.a0 = vreg_addr_t'(a0); v.a1 = vreg_addr_t'(a1); v.a2 = vreg_addr_t'(a2);
      v.ev = ev; v.d0 = d0; v.d1 = d1; v.d2 = d2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
      re = '0; raddr = '0;
   endtask

   initial begin
      // name, we, waddr, wdata, wbe, re, a0, a1, a2, exp rvalid, exp d0, d1, d2
      vecs.push_back(mk("idle",        0, 0, 32'h0,         4'h0, 3'b000, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk("wr5_rd_old",  1, 5, 32'hDEADBEEF,  4'hF, 3'b001, 5, 0, 0, 3'b001, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk("rd5_new",     0, 0, 32'h0,         4'h0, 3'b001, 5, 0, 0, 3'b001, 32'hDEADBEEF, 32'h0, 32'h0));
      vecs.push_back(mk("wr8_rd_old",  1, 8, 32'h11111111,  4'hF, 3'b010, 0, 8, 0, 3'b010, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk("rd8_new",     0, 0, 32'h0,         4'h0, 3'b010, 0, 8, 0, 3'b010, 32'h0, 32'h11111111, 32'h0));
      vecs.push_back(mk("wr3_full",    1, 3, 32'hAABBCCDD,  4'hF, 3'b000, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk("wr3_byte0",   1, 3, 32'h00000011,  4'h1, 3'b100, 0, 0, 3, 3'b100, 32'h0, 32'h0, 32'hAABBCCDD));
      vecs.push_back(mk("rd3_merged",  0, 0, 32'h0,         4'h0, 3'b100, 0, 0, 3, 3'b100, 32'h0, 32'h0, 32'hAABBCC11));
      vecs.push_back(mk("wbe0_write",  1, 3, 32'hFFFFFFFF,  4'h0, 3'b001, 3, 0, 0, 3'b001, 32'hAABBCC11, 32'h0, 32'h0));
      vecs.push_back(mk("rd3_kept",    0, 0, 32'h0,         4'h0, 3'b001, 3, 0, 0, 3'b001, 32'hAABBCC11, 32'h0, 32'h0));
      vecs.push_back(mk("wr0",         1, 0, 32'h0000A00A,  4'hF, 3'b000, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk("wr4",         1, 4, 32'h0000B00B,  4'hF, 3'b000, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk("conf_c1",     0, 0, 32'h0,         4'h0, 3'b111, 0, 4, 8, 3'b001, 32'h0000A00A, 32'h0, 32'h0));
      vecs.push_back(mk("conf_c2",     0, 0, 32'h0,         4'h0, 3'b111, 0, 4, 8, 3'b010, 32'h0, 32'h0000B00B, 32'h0));
      vecs.push_back(mk("conf_c3",     0, 0, 32'h0,         4'h0, 3'b111, 0, 4, 8, 3'b100, 32'h0, 32'h0, 32'h11111111));
      vecs.push_back(mk("distinct",    0, 0, 32'h0,         4'h0, 3'b111, 1, 2, 3, 3'b111, 32'h0, 32'h0, 32'hAABBCC11));
      vecs.push_back(mk("conf_rr0",    0, 0, 32'h0,         4'h0, 3'b111, 0, 4, 8, 3'b001, 32'h0000A00A, 32'h0, 32'h0));
      vecs.push_back(mk("same_addr",   0, 0, 32'h0,         4'h0, 3'b110, 0, 8, 8, 3'b010, 32'h0, 32'h11111111, 32'h0));
      vecs.push_back(mk("wrap",        0, 0, 32'h0,         4'h0, 3'b011, 8, 8, 0, 3'b001, 32'h11111111, 32'h0, 32'h0));
      vecs.push_back(mk("no_reads",    1, 1, 32'h00000001,  4'hF, 3'b000, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0));
      vecs.push_back(mk("rr_hold",     0, 0, 32'h0,         4'h0, 3'b111, 0, 4, 8, 3'b010, 32'h0, 32'h0000B00B, 32'h0));
      vecs.push_back(mk("rr2_pair",    0, 0, 32'h0,         4'h0, 3'b101, 0, 0, 8, 3'b100, 32'h0, 32'h0, 32'h11111111));
      vecs.push_back(mk("rr0_pair",    0, 0, 32'h0,         4'h0, 3'b011, 0, 4, 0, 3'b001, 32'h0000A00A, 32'h0, 32'h0));
      vecs.push_back(mk("single_wrap", 0, 0, 32'h0,         4'h0, 3'b001, 0, 0, 0, 3'b001, 32'h0000A00A, 32'h0, 32'h0));
      vecs.push_back(mk("after_single",0, 0, 32'h0,         4'h0, 3'b011, 0, 4, 0, 3'b010, 32'h0, 32'h0000B00B, 32'h0));
      vecs.push_back(mk("mixed1",      0, 0, 32'h0,         4'h0, 3'b111, 1, 5, 4, 3'b101, 32'h00000001, 32'h0, 32'h0000B00B));
      vecs.push_back(mk("mixed2",      0, 0, 32'h0,         4'h0, 3'b111, 1, 5, 4, 3'b110, 32'h0, 32'hDEADBEEF, 32'h0000B00B));

      // Power-on reset: outputs follow their combinational definitions.
      rst_ni = 1'b0;
      idle();
      re = 3'b001; raddr[0] = 8'd5; we = 1'b1; waddr = 8'd5; wdata = 32'hFFFFFFFF; wbe = 4'hF;
      #3;
      chk("rst_rvalid", 32'(rvalid), 32'(3'b001));
      chk("rst_rdata0", rdata[0], 32'h0);
      chk("rst_wvalid", 32'(wvalid), 32'h1);
      idle();
      #1;
      chk("rst_idle_rvalid", 32'(rvalid), 32'h0);
      chk("rst_idle_wvalid", 32'(wvalid), 32'h0);
      #8 rst_ni = 1'b1;

      foreach (vecs[i]) begin
         @(posedge clk_i);
         #1;
         we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd; wbe = vecs[i].be;
         re = vecs[i].re; raddr[0] = vecs[i].a0; raddr[1] = vecs[i].a1; raddr[2] = vecs[i].a2;
         #3;
         chk({vecs[i].name, " rvalid"}, 32'(rvalid), 32'(vecs[i].ev));
         chk({vecs[i].name, " wvalid"}, 32'(wvalid), 32'(vecs[i].we));
         chk({vecs[i].name, " rdata0"}, rdata[0], vecs[i].d0);
         chk({vecs[i].name, " rdata1"}, rdata[1], vecs[i].d1);
         chk({vecs[i].name, " rdata2"}, rdata[2], vecs[i].d2);
      end

      // Mid-sequence reset: storage and pointers clear without a clock edge,
      // and a write pending across the reset edge is lost.
      @(posedge clk_i);
      #1;
      idle();
      we = 1'b1; waddr = 8'd2; wdata = 32'h12345678; wbe = 4'hF;
      @(posedge clk_i);
      #1;
      idle();
      re = 3'b001; raddr[0] = 8'd2;
      #2;
      chk("wr2_rd", rdata[0], 32'h12345678);
      we = 1'b1; waddr = 8'd2; wdata = 32'hFFFFFFFF; wbe = 4'hF;
      raddr[0] = 8'd3;
      #1 rst_ni = 1'b0;
      #1;
      chk("async_clr_rd3", rdata[0], 32'h0);
      chk("async_rvalid", 32'(rvalid), 32'(3'b001));
      chk("async_wvalid", 32'(wvalid), 32'h1);
      @(posedge clk_i);
      #1;
      we = 1'b0; wbe = '0;
      raddr[0] = 8'd2;
      #1;
      chk("rst_rd2", rdata[0], 32'h0);
      #1 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      idle();
      re = 3'b001; raddr[0] = 8'd2;
      #2;
      chk("post_rst_rd2", rdata[0], 32'h0);
      chk("post_rst_rvalid", 32'(rvalid), 32'(3'b001));
      @(posedge clk_i);
      #1;
      re = 3'b111; raddr[0] = 8'd0; raddr[1] = 8'd4; raddr[2] = 8'd8;
      #2;
      chk("post_rst_conf_rvalid", 32'(rvalid), 32'(3'b001));
      chk("post_rst_conf_rdata0", rdata[0], 32'h0);
      @(posedge clk_i);
      #1;
      re = 3'b011; raddr[0] = 8'd1; raddr[1] = 8'd5;
      #2;
      chk("post_rst_b1_rvalid", 32'(rvalid), 32'(3'b001));
      chk("post_rst_b1_rdata0", rdata[0], 32'h0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
